seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed hex driver for the common-anode 7-segment bank on the Nexys4 DDR board, default 8 digits. It replaces static single-digit drive: it scans one digit per refresh slot, decodes each nibble to segments, and applies per-digit enable and decimal point. New display values are staged and committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
dp_in  input  NUM_DIGITS  decimal point request per digit, active high.
digit_en  input  NUM_DIGITS  per-digit enable, active high; sampled live, not staged.
load  input  1  single-cycle strobe; captures value and dp_in into the staging register.
an  output  NUM_DIGITS  anode selects, active low.
seg  output  7  segments {g,f,e,d,c,b,a} = seg[6:0], active low.
dp  output  1  decimal point, active low.
frame_done  output  1  one-cycle pulse when the last digit slot of a frame ends.

Behaviour:
- Reset, asynchronous: an all ones, seg 7'h7F, dp 1, frame_done 0, prescaler 0, digit index 0, staging and display registers 0, pending flag 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (count == REFRESH_DIV-1).
- On tick, the digit index advances; it wraps from NUM_DIGITS-1 to 0. A frame boundary is a tick with index == NUM_DIGITS-1.
- frame_done is asserted in the cycle after the boundary tick, for exactly one cycle.
- When load=1, value and dp_in are captured into staging and pending is set.
- At a frame boundary with pending=1, staging is copied to the display register and pending is cleared.
- If load coincides with a boundary tick, the newly presented value is committed directly at that boundary and pending remains 0.
- Repeated loads within one frame: the last load wins.
- an, seg and dp are registered. They update one cycle after the index changes, and one cycle after reset release for slot 0.
- For the current index i with digit_en[i]=1: an has only bit i low, seg = decode(display nibble i), dp = ~display_dp[i].
- With digit_en[i]=0: an all ones, seg 7'h7F, dp 1. The slot still consumes its full time.
- Hex decode, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Never more than one anode is low at a time, including during transitions.
- Prescaler width is $clog2(REFRESH_DIV); index width is $clog2(NUM_DIGITS), minimum 1.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: an enabled digit i>0 is blanked (an high, seg 7'h7F, dp 1) when its display nibble and every higher-index display nibble are 0 and none of those digits has dp set. Digit 0 is never blanked by this rule. The blank mask is computed from the display register, so it changes only at commits.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
1. REFRESH_DIV=4, reset held then released -> an=8'hFF and seg=7'h7F during reset; first digit-0 drive (an=8'hFE) appears 1 cycle after release; index advances every 4 clk; frame_done pulses once every 32 clk.
2. load value=32'h0000_0019, digit_en=8'hFF, dp_in=0 -> after the next frame boundary: slot 0 seg=0010000, slot 1 seg=1111001, slots 2..7 seg=1000000; with SEG7_LEADING_ZERO_BLANK_EN defined, slots 2..7 are instead an=8'hFF, seg=7'h7F.
3. load 32'hDEAD_BEEF mid-frame, then load 32'h1234_5678 in the same frame -> the current frame is unchanged; the next frame shows 1234_5678 only (slot 0 seg=0000000, slot 7 seg=1111001).
4. digit_en=8'b0000_0101, dp_in=8'h01 -> only slots 0 and 2 drive an low; slot 0 dp=0; all other slots have an all ones, dp=1.
5. Assert reset in the middle of slot 3 -> outputs blank asynchronously in the same cycle; after release, the display register is 0 and scanning restarts from slot 0.
6. load asserted exactly on a boundary tick with value=32'hFFFF_FFFF -> committed at that boundary; the next frame shows seg=0001110 on all digits; pending stays 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a common-anode 7-segment bank with frame-synchronous value commits.
// Optional leading-zero blanking is enabled with SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stage_val;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic                    tick;
    logic                    last_slot;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [6:0]              seg_nx;
    logic                    dp_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick      = (cnt == PW'(REFRESH_DIV - 1));
    assign last_slot = (idx == IW'(NUM_DIGITS - 1));
    assign boundary  = tick && last_slot;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Walk from the most significant digit down; a digit blanks while everything above it is a bare zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run && (disp_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                                && !disp_dp[NUM_DIGITS-1-k];
            if (k != NUM_DIGITS - 1)
                blank[NUM_DIGITS-1-k] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        an_nx  = '1;
        seg_nx = 7'h7F;
        dp_nx  = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i) && digit_en[i] && !blank[i]) begin
                an_nx[i] = 1'b0;
                seg_nx   = hex7(disp_val[4*i +: 4]);
                dp_nx    = ~disp_dp[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            stage_val  <= '0;
            stage_dp   <= '0;
            pending    <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            an         <= an_nx;
            seg        <= seg_nx;
            dp         <= dp_nx;
            frame_done <= boundary;

            cnt <= tick ? '0 : cnt + PW'(1);
            if (tick)
                idx <= last_slot ? '0 : idx + IW'(1);

            if (load) begin
                stage_val <= value;
                stage_dp  <= dp_in;
            end

            // A load landing on the boundary bypasses staging so the new value is not a frame late.
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                end else if (pending) begin
                    disp_val <= stage_val;
                    disp_dp  <= stage_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (8 digits, 4 clk per slot).
// The model says: a frame shows the last value loaded on an edge before that frame began.
module tb_seg7_scan_driver;

    localparam int ND  = 8;
    localparam int DIV = 4;
    localparam int FRM = ND * DIV;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp_in;
    logic [ND-1:0]   digit_en;
    logic            load;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_done;

    int tests  = 0;
    int failed = 0;
    int cyc;

    typedef struct {
        int          at;
        logic [31:0] v;
        logic [7:0]  d;
    } ld_t;
    ld_t loads[$];

    logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    localparam logic [16:0] RST_OUT = {8'hFF, 7'h7F, 1'b1, 1'b0};

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Edges completed since reset release; at a negedge the last edge index is cyc-1.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Expected {an, seg, dp, frame_done} right after edge e.
    function automatic logic [16:0] model(int e);
        int          slot;
        int          fstart;
        logic [31:0] dv;
        logic [7:0]  dd;
        logic [7:0]  ea;
        logic [6:0]  es;
        logic        ep;
        logic        blanked;
        slot   = (e / DIV) % ND;
        fstart = (e / FRM) * FRM;
        dv = '0;
        dd = '0;
        foreach (loads[i]) if (loads[i].at < fstart) begin
            dv = loads[i].v;
            dd = loads[i].d;
        end
        blanked = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (dv >> (4 * slot)) == 0 && (dd >> slot) == 0) blanked = 1'b1;
`endif
        ea = 8'hFF;
        es = 7'h7F;
        ep = 1'b1;
        if (digit_en[slot] && !blanked) begin
            ea = ~(8'd1 << slot);
            es = segtab[(dv >> (4 * slot)) & 32'hF];
            ep = ~dd[slot];
        end
        return {ea, es, ep, (e % FRM) == FRM - 1};
    endfunction

    task automatic do_load(input logic [31:0] v, input logic [7:0] d);
        ld_t r;
        load  = 1'b1;
        value = v;
        dp_in = d;
        r.at = cyc;
        r.v  = v;
        r.d  = d;
        loads.push_back(r);
    endtask

    task automatic test_reset();
        logic [16:0] exp;
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = 8'hFF;
        loads.delete();
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({an, seg, dp, frame_done} !== RST_OUT) begin
                failed++;
                $display("FAIL reset_hold got=%h exp=%h", {an, seg, dp, frame_done}, RST_OUT);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tests++;
                if (an !== 8'hFE) begin
                    failed++;
                    $display("FAIL first_drive an got=%h exp=fe", an);
                end
            end
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL reset_scan cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
        end
    endtask

    task automatic test_decode();
        logic [16:0] exp;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL decode cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
            load = 1'b0;
            if (k == 5) do_load(32'h0000_0019, 8'h00);
        end
    endtask

    task automatic test_last_wins();
        logic [16:0] exp;
        bit l1 = 0, l2 = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL last_wins cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
            load = 1'b0;
            if (!l1 && cyc % FRM == 8) begin
                do_load(32'hDEAD_BEEF, 8'h00);
                l1 = 1;
            end else if (l1 && !l2 && cyc % FRM == 20) begin
                do_load(32'h1234_5678, 8'h00);
                l2 = 1;
            end
        end
    endtask

    task automatic test_enable_dp();
        logic [16:0] exp;
        digit_en = 8'b0000_0101;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL enable_dp cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
            load = 1'b0;
            if (k == 1) do_load(32'h8765_4321, 8'h01);
        end
        digit_en = 8'hFF;
    endtask

    task automatic test_boundary_load();
        logic [16:0] exp;
        bit done = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL boundary_load cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
            if (load && done) begin
                tests++;
                if (dut.pending !== 1'b0) begin
                    failed++;
                    $display("FAIL boundary_pending got=%b exp=0", dut.pending);
                end
            end
            load = 1'b0;
            if (!done && k > 2 && cyc % FRM == FRM - 1) begin
                do_load(32'hFFFF_FFFF, 8'h00);
                done = 1;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp;
        int guard = 0;
        do_load(32'hA5C3_9E71, 8'h24);
        @(negedge clk);
        load = 1'b0;
        while (cyc % FRM != 3 * DIV + 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (guard >= 200) begin
            failed++;
            $display("FAIL reset_mid_align got=%0d exp=%0d", cyc % FRM, 3 * DIV + 2);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({an, seg, dp, frame_done} !== RST_OUT) begin
            failed++;
            $display("FAIL reset_async got=%h exp=%h", {an, seg, dp, frame_done}, RST_OUT);
        end
        @(negedge clk);
        loads.delete();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL reset_mid_scan cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] exp;
        logic [31:0] rv;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            exp = model(cyc - 1);
            tests++;
            if ({an, seg, dp, frame_done} !== exp) begin
                failed++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {an, seg, dp, frame_done}, exp);
            end
            load = 1'b0;
            if ($urandom_range(0, 99) < 12) begin
                rv = $urandom;
                if ($urandom_range(0, 2) == 0) rv = rv >> (4 * $urandom_range(1, 7));
                do_load(rv, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
            end
            if ($urandom_range(0, 99) < 4) digit_en = 8'($urandom);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_last_wins();
        test_enable_dp();
        test_boundary_load();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
